// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART on the MEM-stage data bus.
// Registers: TXD at BASE_ADDR, RXD at BASE_ADDR+4, CON/status at BASE_ADDR+8.
// Loads are combinational; irq is a registered level request.
// Build option: define UART_LOOPBACK_EN to add CON bit 7 (lpbk), which routes
// the internal TX serial stream into the RX synchroniser and parks the pin high.
module uart_mmio #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);

    // Clocks per 16x oversample tick; must be at least 2.
    localparam int unsigned DIV       = CLK_FREQ / (BAUD * 16);
    localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign sel_txd = (addr == BASE_ADDR);
    assign sel_rxd = (addr == (BASE_ADDR + 32'd4));
    assign sel_con = (addr == (BASE_ADDR + 32'd8));
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;
    assign rd_rxd  = rd & sel_rxd;
    assign rd_con  = rd & sel_con;

    // Only the low byte (and CON control bits) of store data is meaningful.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:2];

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    assign tick = (cnt_q == TICK_LAST);

    // Free-running divider next state.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Divider register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // ------------------------------------------------------------------
    // Control register (interrupt enables, optional loopback)
    // ------------------------------------------------------------------
    logic tx_ie_q, tx_ie_d;
    logic rx_ie_q, rx_ie_d;
    logic lpbk_bit;
`ifdef UART_LOOPBACK_EN
    logic lpbk_q, lpbk_d;
    assign lpbk_bit = lpbk_q;
`else
    assign lpbk_bit = 1'b0;
`endif

    // CON writes update the enables; other bits are ignored.
    always_comb begin
        tx_ie_d = tx_ie_q;
        rx_ie_d = rx_ie_q;
`ifdef UART_LOOPBACK_EN
        lpbk_d  = lpbk_q;
`endif
        if (wr_con) begin
            tx_ie_d = wdata[0];
            rx_ie_d = wdata[1];
`ifdef UART_LOOPBACK_EN
            lpbk_d  = wdata[7];
`endif
        end
    end

    // Control register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ie_q <= 1'b0;
            rx_ie_q <= 1'b0;
`ifdef UART_LOOPBACK_EN
            lpbk_q  <= 1'b0;
`endif
        end else begin
            tx_ie_q <= tx_ie_d;
            rx_ie_q <= rx_ie_d;
`ifdef UART_LOOPBACK_EN
            lpbk_q  <= lpbk_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [3:0]  tx_phase_q, tx_phase_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_end;

    // TX next state: latch on idle write, 16 ticks per start/data/stop bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_phase_d = tx_phase_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_busy_d  = tx_busy_q;
        tx_end     = 1'b0;
        tx_line_d  = 1'b1;

        if (wr_txd && !tx_busy_q) begin
            tx_data_d = wdata[7:0];
            tx_busy_d = 1'b1;
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_busy_q && tick) begin
                    tx_state_d = TX_START;
                    tx_phase_d = '0;
                end
            end
            default: begin
                if (tick) begin
                    tx_phase_d = tx_phase_q + 4'd1;
                    if (tx_phase_q == 4'd15) begin
                        case (tx_state_q)
                            TX_START: begin
                                tx_state_d = TX_DATA;
                                tx_bit_d   = '0;
                            end
                            TX_DATA: begin
                                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                                else                  tx_bit_d   = tx_bit_q + 3'd1;
                            end
                            default: begin
                                tx_state_d = TX_IDLE;
                                tx_busy_d  = 1'b0;
                                tx_end     = 1'b1;
                            end
                        endcase
                    end
                end
            end
        endcase

        // Line level follows the next state so the pin is glitch-free.
        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_data_q[tx_bit_d];
            default:  tx_line_d = 1'b1;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_phase_q <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            tx_busy_q  <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_phase_q <= tx_phase_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
            tx_busy_q  <= tx_busy_d;
            tx_line_q  <= tx_line_d;
        end
    end

`ifdef UART_LOOPBACK_EN
    assign UART_TX = lpbk_q ? 1'b1 : tx_line_q;
`else
    assign UART_TX = tx_line_q;
`endif

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_src;
`ifdef UART_LOOPBACK_EN
    assign rx_src = lpbk_q ? tx_line_q : UART_RX;
`else
    assign rx_src = UART_RX;
`endif

    logic rx_s1_q, rx_s2_q, rx_prev_q;

    // Two-flop synchroniser plus previous-value flop for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_src;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  rx_phase_q, rx_phase_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_mid;
    logic        rx_good, rx_ferr;

    // Phase is restarted on the start edge, so phase 7 is mid-bit.
    assign rx_mid = tick && (rx_phase_q == 4'd7);

    // RX next state: edge-armed start, mid-bit sampling, stop-bit check.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_phase_d = rx_phase_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_good    = 1'b0;
        rx_ferr    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_phase_d = '0;
                end
            end
            default: begin
                if (tick) rx_phase_d = rx_phase_q + 4'd1;
                if (rx_mid) begin
                    case (rx_state_q)
                        RX_START: begin
                            if (rx_s2_q) begin
                                rx_state_d = RX_IDLE;
                            end else begin
                                rx_state_d = RX_DATA;
                                rx_bit_d   = '0;
                            end
                        end
                        RX_DATA: begin
                            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                            else                  rx_bit_d   = rx_bit_q + 3'd1;
                        end
                        default: begin
                            rx_state_d = RX_IDLE;
                            if (rx_s2_q) begin
                                rx_data_d = rx_shift_q;
                                rx_good   = 1'b1;
                            end else begin
                                rx_ferr   = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // RX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_phase_q <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_phase_q <= rx_phase_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Status flags and interrupt
    // ------------------------------------------------------------------
    logic tx_done_q, tx_done_d;
    logic rx_valid_q, rx_valid_d;
    logic ovr_q, ovr_d;
    logic frm_err_q, frm_err_d;
    logic irq_q, irq_d;

    // Flags: a set in the same cycle as a read-clear takes priority.
    always_comb begin
        tx_done_d  = tx_end  ? 1'b1 : (rd_con ? 1'b0 : tx_done_q);
        frm_err_d  = rx_ferr ? 1'b1 : (rd_con ? 1'b0 : frm_err_q);
        rx_valid_d = rx_good ? 1'b1 : (rd_rxd ? 1'b0 : rx_valid_q);
        ovr_d      = (rx_good && rx_valid_q) ? 1'b1 : (rd_rxd ? 1'b0 : ovr_q);
        irq_d      = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_valid_q);
    end

    // Flag and interrupt registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_done_q  <= tx_done_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            frm_err_q  <= frm_err_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    // ------------------------------------------------------------------
    // Combinational load data
    // ------------------------------------------------------------------
    logic [7:0] con_val;
    assign con_val = {lpbk_bit, frm_err_q, ovr_q, tx_busy_q,
                      rx_valid_q, tx_done_q, rx_ie_q, tx_ie_q};

    // Read mux: zero unless a load hits one of the three registers.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)      rdata = {24'd0, tx_data_q};
            else if (sel_rxd) rdata = {24'd0, rx_data_q};
            else if (sel_con) rdata = {24'd0, con_val};
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: randomized self-checking bench for uart_mmio at DIV=10
// (160 clocks per bit). Expected frames and status words are built from
// the register map and 8N1 framing rules, not from the design internals.
module tb_uart_mmio;

    localparam logic [31:0] BASE  = 32'h40000018;
    localparam logic [31:0] A_TXD = BASE;
    localparam logic [31:0] A_RXD = BASE + 32'd4;
    localparam logic [31:0] A_CON = BASE + 32'd8;
`ifdef UART_LOOPBACK_EN
    localparam bit LPBK = 1'b1;
`else
    localparam bit LPBK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        UART_RX, UART_TX, irq;

    int vectors = 0;
    int miscompares = 0;

    // Receive-side model: bytes accepted since the last RXD read.
    logic [7:0] rx_hist[$];
    logic [7:0] last_rx = 8'h00;

    uart_mmio #(
        .CLK_FREQ (1600000),
        .BAUD     (10000),
        .BASE_ADDR(BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .UART_RX(UART_RX),
        .UART_TX(UART_TX),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Expected CON word from individual flag values.
    function automatic logic [31:0] exp_con(bit lp, bit frm, bit ovr, bit busy,
                                            bit rxv, bit txd, bit rxie, bit txie);
        return {24'd0, lp, frm, ovr, busy, rxv, txd, rxie, txie};
    endfunction

    function automatic logic [9:0] frame_of(logic [7:0] b, logic stop);
        return {stop, b, 1'b0};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); wr = 1'b1; addr = a; wdata = d;
        @(negedge clk); wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk); rd = 1'b0; addr = '0;
    endtask

    // Wait for the start edge, then sample each of the 10 bits at mid-bit.
    task automatic capture_tx(input bit inject, input logic [7:0] inj,
                              output logic [9:0] bits, output bit ok);
        int n;
        bits = '1; ok = 1'b0; n = 0;
        while (UART_TX !== 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
        if (UART_TX === 1'b0) begin
            ok = 1'b1;
            repeat (80) @(posedge clk);
            #1;
            for (int i = 0; i < 10; i++) begin
                bits[i] = UART_TX;
                if (i < 9) begin
                    if (inject && i == 2) begin
                        bus_write(A_TXD, {24'd0, inj});
                        repeat (159) @(posedge clk);
                    end else begin
                        repeat (160) @(posedge clk);
                    end
                    #1;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = frame_of(b, stop);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            UART_RX = f[i];
            repeat (160) @(negedge clk);
        end
        UART_RX = 1'b1;
    endtask

    task automatic wait_irq(input string tag, input int limit);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_irq: irq=%b required 1 within %0d cycles", tag, irq, limit);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0; rd = 1'b1; addr = A_CON;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (UART_TX !== 1'b1) begin miscompares++; $display("FAIL reset_tx: UART_TX=%b required 1", UART_TX); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: irq=%b required 0", irq); end
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: rdata=%h required 0", rdata); end
        rd = 1'b0; addr = '0;
        @(negedge clk); reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        vectors++;
        if (UART_TX !== 1'b1) begin miscompares++; $display("FAIL idle_tx: UART_TX=%b required 1", UART_TX); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL idle_irq: irq=%b required 0", irq); end
        bus_read(A_CON, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL idle_con: CON=%h required 0", d); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic [9:0]  bits;
        logic [7:0]  b;
        bit          ok;
        bus_write(A_CON, 32'h1);
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            bus_write(A_TXD, {24'd0, b});
            capture_tx(1'b0, 8'h00, bits, ok);
            vectors++;
            if (!ok || bits !== frame_of(b, 1'b1)) begin
                miscompares++;
                $display("FAIL tx_frame: byte %h line bits=%b (started=%0d) required %b",
                         b, bits, ok, frame_of(b, 1'b1));
            end
            bus_read(A_CON, d);
            vectors++;
            if (d !== exp_con(0, 0, 0, 1, 0, 0, 0, 1)) begin
                miscompares++; $display("FAIL tx_busy: CON=%h required %h", d, exp_con(0, 0, 0, 1, 0, 0, 0, 1));
            end
            wait_irq("tx", 200);
            bus_read(A_CON, d);
            vectors++;
            if (d !== exp_con(0, 0, 0, 0, 0, 1, 0, 1)) begin
                miscompares++; $display("FAIL tx_done: CON=%h required %h", d, exp_con(0, 0, 0, 0, 0, 1, 0, 1));
            end
            bus_read(A_CON, d);
            vectors++;
            if (d !== exp_con(0, 0, 0, 0, 0, 0, 0, 1)) begin
                miscompares++; $display("FAIL tx_clr: CON=%h required %h", d, exp_con(0, 0, 0, 0, 0, 0, 0, 1));
            end
            repeat (2) @(posedge clk);
            #1;
            vectors++;
            if (irq !== 1'b0) begin miscompares++; $display("FAIL tx_irq_drop: irq=%b required 0", irq); end
        end
    endtask

    task automatic test_busy_drop();
        logic [31:0] d;
        logic [9:0]  bits;
        logic [7:0]  b1;
        bit          ok;
        int          lows;
        b1 = 8'($urandom_range(0, 255));
        bus_write(A_TXD, {24'd0, b1});
        capture_tx(1'b1, ~b1, bits, ok);
        vectors++;
        if (!ok || bits !== frame_of(b1, 1'b1)) begin
            miscompares++;
            $display("FAIL drop_frame: line bits=%b (started=%0d) required %b", bits, ok, frame_of(b1, 1'b1));
        end
        wait_irq("drop", 200);
        bus_read(A_TXD, d);
        vectors++;
        if (d !== {24'd0, b1}) begin miscompares++; $display("FAIL drop_txd: TXD=%h required %h", d, {24'd0, b1}); end
        bus_read(A_CON, d);
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (UART_TX === 1'b0) lows++;
        end
        vectors++;
        if (lows !== 0) begin miscompares++; $display("FAIL drop_second: %0d low cycles after frame, required 0", lows); end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        logic [7:0]  b;
        bus_write(A_CON, 32'h2);
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            rx_hist.push_back(b); last_rx = b;
            wait_irq("rx", 160);
            bus_read(A_CON, d);
            vectors++;
            if (d !== exp_con(0, 0, rx_hist.size() > 1, 0, 1, 0, 1, 0)) begin
                miscompares++; $display("FAIL rx_valid: CON=%h required %h", d, exp_con(0, 0, rx_hist.size() > 1, 0, 1, 0, 1, 0));
            end
            bus_read(A_RXD, d);
            vectors++;
            if (d !== {24'd0, rx_hist[$]}) begin
                miscompares++; $display("FAIL rx_data: RXD=%h required %h", d, {24'd0, rx_hist[$]});
            end
            rx_hist.delete();
            bus_read(A_CON, d);
            vectors++;
            if (d !== exp_con(0, 0, 0, 0, 0, 0, 1, 0)) begin
                miscompares++; $display("FAIL rx_clr: CON=%h required %h", d, exp_con(0, 0, 0, 0, 0, 0, 1, 0));
            end
            repeat (2) @(posedge clk);
            #1;
            vectors++;
            if (irq !== 1'b0) begin miscompares++; $display("FAIL rx_irq_drop: irq=%b required 0", irq); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  b;
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            rx_hist.push_back(b); last_rx = b;
        end
        repeat (20) @(posedge clk);
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(0, 0, rx_hist.size() > 1, 0, 1, 0, 1, 0)) begin
            miscompares++; $display("FAIL b2b_ovr: CON=%h required %h", d, exp_con(0, 0, rx_hist.size() > 1, 0, 1, 0, 1, 0));
        end
        bus_read(A_RXD, d);
        vectors++;
        if (d !== {24'd0, rx_hist[$]}) begin
            miscompares++; $display("FAIL b2b_data: RXD=%h required %h", d, {24'd0, rx_hist[$]});
        end
        rx_hist.delete();
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(0, 0, 0, 0, 0, 0, 1, 0)) begin
            miscompares++; $display("FAIL b2b_clr: CON=%h required %h", d, exp_con(0, 0, 0, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_glitch_framing();
        logic [31:0] d;
        logic [7:0]  a, c;
        @(negedge clk); UART_RX = 1'b0;
        repeat (10) @(negedge clk);
        UART_RX = 1'b1;
        repeat (400) @(posedge clk);
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(0, 0, 0, 0, 0, 0, 1, 0)) begin
            miscompares++; $display("FAIL glitch: CON=%h required %h", d, exp_con(0, 0, 0, 0, 0, 0, 1, 0));
        end
        a = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 255));
        send_frame(a, 1'b1);
        rx_hist.push_back(a); last_rx = a;
        send_frame(c, 1'b0);
        repeat (20) @(posedge clk);
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(0, 1, 0, 0, 1, 0, 1, 0)) begin
            miscompares++; $display("FAIL frm_err: CON=%h required %h", d, exp_con(0, 1, 0, 0, 1, 0, 1, 0));
        end
        bus_read(A_RXD, d);
        vectors++;
        if (d !== {24'd0, a}) begin miscompares++; $display("FAIL frm_data: RXD=%h required %h", d, {24'd0, a}); end
        rx_hist.delete();
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(0, 0, 0, 0, 0, 0, 1, 0)) begin
            miscompares++; $display("FAIL frm_clr: CON=%h required %h", d, exp_con(0, 0, 0, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_con_bits();
        logic [31:0] d;
        bus_write(A_CON, 32'hFFFF_FF83);
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(LPBK, 0, 0, 0, 0, 0, 1, 1)) begin
            miscompares++; $display("FAIL con_rw: CON=%h required %h", d, exp_con(LPBK, 0, 0, 0, 0, 0, 1, 1));
        end
        bus_write(A_CON, 32'h0);
        bus_write(A_RXD, 32'hFF);
        bus_read(A_RXD, d);
        vectors++;
        if (d !== {24'd0, last_rx}) begin miscompares++; $display("FAIL rxd_write: RXD=%h required %h", d, {24'd0, last_rx}); end
        bus_read(A_CON, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL con_zero: CON=%h required 0", d); end
        bus_read(BASE + 32'd2, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL unaligned: rdata=%h required 0", d); end
        @(negedge clk); addr = A_CON; rd = 1'b0;
        #1;
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("FAIL no_rd: rdata=%h required 0", rdata); end
        addr = '0;
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        logic [9:0]  bits;
        logic [7:0]  b;
        bit          ok;
        int          n;
        bus_write(A_CON, 32'h1);
        bus_write(A_TXD, 32'h0);
        n = 0;
        while (UART_TX !== 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
        repeat (300) @(posedge clk);
        #1;
        vectors++;
        if (UART_TX !== 1'b0) begin miscompares++; $display("FAIL mid_frame: UART_TX=%b required 0", UART_TX); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (UART_TX !== 1'b1) begin miscompares++; $display("FAIL async_rst_tx: UART_TX=%b required 1", UART_TX); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL async_rst_irq: irq=%b required 0", irq); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_read(A_CON, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL rst_con: CON=%h required 0", d); end
        bus_write(A_CON, 32'h1);
        b = 8'($urandom_range(0, 255));
        bus_write(A_TXD, {24'd0, b});
        capture_tx(1'b0, 8'h00, bits, ok);
        vectors++;
        if (!ok || bits !== frame_of(b, 1'b1)) begin
            miscompares++;
            $display("FAIL post_rst_frame: line bits=%b (started=%0d) required %b", bits, ok, frame_of(b, 1'b1));
        end
        wait_irq("post_rst", 200);
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(0, 0, 0, 0, 0, 1, 0, 1)) begin
            miscompares++; $display("FAIL post_rst_con: CON=%h required %h", d, exp_con(0, 0, 0, 0, 0, 1, 0, 1));
        end
    endtask

`ifdef UART_LOOPBACK_EN
    task automatic test_loopback();
        logic [31:0] d;
        logic [7:0]  b;
        int          lows;
        b = (LPBK) ? 8'h7E : 8'h00;
        bus_write(A_CON, 32'h83);
        bus_write(A_TXD, {24'd0, b});
        lows = 0;
        for (int i = 0; i < 1800; i++) begin
            @(posedge clk); #1;
            if (UART_TX === 1'b0) lows++;
        end
        vectors++;
        if (lows !== 0) begin miscompares++; $display("FAIL lpbk_pin: %0d low cycles on UART_TX, required 0", lows); end
        bus_read(A_CON, d);
        vectors++;
        if (d !== exp_con(1, 0, 0, 0, 1, 1, 1, 1)) begin
            miscompares++; $display("FAIL lpbk_con: CON=%h required %h", d, exp_con(1, 0, 0, 0, 1, 1, 1, 1));
        end
        bus_read(A_RXD, d);
        vectors++;
        if (d !== {24'd0, b}) begin miscompares++; $display("FAIL lpbk_data: RXD=%h required %h", d, {24'd0, b}); end
        bus_write(A_CON, 32'h0);
    endtask
`endif

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; wdata = '0; UART_RX = 1'b1;
        test_reset();
        test_tx();
        test_busy_drop();
        test_rx();
        test_back_to_back();
        test_glitch_framing();
        test_con_bits();
        test_reset_mid_tx();
`ifdef UART_LOOPBACK_EN
        test_loopback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped UART controller on the CPU's MEM-stage data bus (address bit 30 set = peripheral space). It decodes three word registers (TX data, RX data, control/status), serialises and deserialises 8N1 frames on UART_TX/UART_RX, and raises a level interrupt request toward the hazard/interrupt logic. Reads are combinational so the loaded value lands in MEM_MemOut in the same cycle.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
BASE_ADDR, 32'h40000018, byte address of TXD; RXD = BASE+4, CON = BASE+8
DIV = CLK_FREQ/(BAUD*16) (localparam), clocks per 16x oversample tick; must be >= 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rd  in  1  bus read strobe; one cycle per load
wr  in  1  bus write strobe; one cycle per store
addr  in  32  byte address; only exact word matches on BASE/BASE+4/BASE+8 select
wdata  in  32  store data
rdata  out  32  load data, combinational
UART_RX  in  1  serial input, asynchronous to clk
UART_TX  out  1  serial output, idle high
irq  out  1  registered interrupt request, level

Behaviour:
- Reset (reset=0, async): UART_TX=1, irq=0, all flags/enables 0, TX/RX FSMs IDLE, tick counter 0. rdata derives only from state and address, so it is 0.
- Tick: free-running counter 0..DIV-1; tick pulses one cycle when counter = DIV-1.
- rdata: rd & TXD -> {24'b0, last written TX byte}; rd & RXD -> {24'b0, rx_data}; rd & CON -> {25'b0, frm_err, ovr, tx_busy, rx_valid, tx_done, rx_ie, tx_ie}; otherwise 0.
- Writes: TXD write with tx_busy=0 latches wdata[7:0], sets tx_busy next edge. A TXD write while busy is dropped and has no effect. A CON write updates tx_ie=wdata[0] and rx_ie=wdata[1]; other bits are ignored. An RXD write is ignored.
- Read side effects, on the edge where rd is high and the address matches: RXD clears rx_valid and ovr; CON clears tx_done and frm_err. If a set and a clear of the same flag occur in one cycle, the set wins.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state/bit lasts 16 ticks.
  - START begins at the first tick after the latch.
  - At the end of STOP: tx_busy=0 and tx_done=1.
- RX input: 2-FF synchroniser.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: synchronised falling edge enters START and restarts the local 16-tick phase.
  - START: samples at tick 8; if the line is high (false start), return to IDLE.
  - DATA: samples each bit every 16 ticks at mid-bit, LSB first.
  - STOP: samples at mid-bit. If 1: rx_data <= byte and rx_valid <= 1; if rx_valid was already 1, also ovr <= 1 (new byte overwrites). If 0: frm_err <= 1 and the byte is discarded.
  - Returns to IDLE after the stop-bit sample, so a back-to-back frame is accepted.
- irq <= (tx_ie & tx_done) | (rx_ie & rx_valid), registered: one-cycle lag after the flag changes.
- TX and RX operate fully concurrently and independently.

Optional Feature:
UART_LOOPBACK_EN: when defined, CON bit 7 (lpbk) is read/write, reset 0. When lpbk=1, the RX synchroniser input is the internal TX serial output and the UART_TX pin is held 1. When not defined, bit 7 reads 0, writes are ignored, and there is no mux on the RX path.

Test Plan:
All scenarios use CLK_FREQ=1600000 and BAUD=10000, giving DIV=10 and 160 clocks per bit.
1. Reset, then idle 100 cycles -> UART_TX=1, irq=0, CON reads 0x00.
2. Write TXD=0xA5, CON=0x01 -> UART_TX bit sequence 0,1,0,1,0,0,1,0,1,1, each 160 clks ±10. tx_busy=1 during the frame, then tx_done=1 and irq=1. A CON read returns 0x05, then the next CON read returns 0x01 and irq drops.
3. Drive 8N1 frame 0x3C on UART_RX with rx_ie=1 -> rx_valid=1 and irq=1 within 1 bit time after the stop bit. RXD reads 0x3C, then CON bit 3 reads 0 and irq=0.
4. Two frames 0x11 then 0x22 with no RXD read between -> RXD reads 0x22 and CON bit 5 (ovr) reads 1. The RXD read clears ovr.
5. Write TXD=0x55 while busy with 0xA5 -> only 0xA5 is transmitted. A 1-tick low glitch on UART_RX gives no rx_valid. A frame with stop bit 0 sets frm_err and leaves rx_valid unchanged.
6. Assert reset mid-TX frame -> UART_TX=1 immediately. After release, a fresh TXD write transmits normally. With UART_LOOPBACK_EN, set lpbk=1 and write 0x7E -> UART_TX stays 1 and RXD reads 0x7E.
